// File: rtl/sd_converter_if.sv
// Handshake bundle for the stochastic-to-digital converter: stream input side,
// result output side and the busy status flag.
interface sd_converter_if #(
    parameter int PRECISION = 8
);
    logic                 start;
    logic                 in_valid;
    logic                 in;
    logic                 in_ready;
    logic [PRECISION-1:0] out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;

    // Converter side
    modport slave (
        input  start,
        input  in_valid,
        input  in,
        input  out_ready,
        output in_ready,
        output out,
        output out_valid,
        output busy
    );

    // Producer / consumer side
    modport master (
        output start,
        output in_valid,
        output in,
        output out_ready,
        input  in_ready,
        input  out,
        input  out_valid,
        input  busy
    );
endinterface

// File: rtl/sd_converter.sv
// Stochastic-to-digital converter. Counts the 1s of a unipolar bitstream over a
// window of 2^PRECISION-1 valid samples (one full LFSR period) and presents the
// count as a PRECISION-bit result with a valid/ready handshake.
// PRECISION must be at least 2.
module sd_converter #(
    parameter int PRECISION = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    sd_converter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Value of the sample counter when the W-th (last) sample of a window arrives.
    localparam logic [PRECISION-1:0] LAST_SAMPLE = {{(PRECISION-1){1'b1}}, 1'b0};
    localparam logic [PRECISION-1:0] ZERO        = {PRECISION{1'b0}};
    localparam logic [PRECISION-1:0] ONE         = {{(PRECISION-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic [PRECISION-1:0] ones_q, ones_d;
    logic [PRECISION-1:0] samples_q, samples_d;
    logic [PRECISION-1:0] out_q, out_d;
    logic [PRECISION-1:0] bit_inc_s;

    // The stream bit widened to counter width; a window never exceeds 2^P-1 ones.
    assign bit_inc_s = {{(PRECISION-1){1'b0}}, bus.in};

    // Next-state logic: window control, sample/ones accumulation and result capture.
    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        samples_d = samples_q;
        out_d     = out_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ones_d    = ZERO;
                    samples_d = ZERO;
                    state_d   = ACCUM;
                end else begin
                    state_d   = IDLE;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    samples_d = samples_q + ONE;
                    ones_d    = ones_q + bit_inc_s;
                    if (samples_q == LAST_SAMPLE) begin
                        // Last sample of the window counts toward the result directly.
                        out_d   = ones_q + bit_inc_s;
                        state_d = DONE;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        // Back-to-back window without passing through IDLE.
                        ones_d    = ZERO;
                        samples_d = ZERO;
                        state_d   = ACCUM;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and result register; reset discards any partial window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ones_q    <= ZERO;
            samples_q <= ZERO;
            out_q     <= ZERO;
        end else begin
            state_q   <= state_d;
            ones_q    <= ones_d;
            samples_q <= samples_d;
            out_q     <= out_d;
        end
    end

    // Outputs are the result register or decoded from the registered state.
    assign bus.out       = out_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sd_converter.sv
// Scoreboard bench for sd_converter (PRECISION=4, window of 15 samples).
// The driver generates random windows and pushes the number of 1s it delivered
// as valid samples; a monitor pops and compares on every result handshake.
module tb_sd_converter;

    localparam int P = 4;
    localparam int W = (1 << P) - 1;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    sd_converter_if #(.PRECISION(P)) bus ();

    sd_converter #(.PRECISION(P)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int sb_q[$];
    int last_exp = 0;
    bit chained  = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every accepted result must match the oldest pending expectation.
    always @(negedge clk_i) begin
        if (rst_ni && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("result", int'(bus.out), sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_idle();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("accum_in_ready", int'(bus.in_ready), 1);
        chk("accum_busy", int'(bus.busy), 1);
    endtask

    // Deliver one full window; p_pct = chance of a 1, gap_pct = chance of a gap cycle.
    task automatic window(input int p_pct, input int gap_pct, input bit gap_one);
        int ones = 0;
        bit b;
        for (int s = 0; s < W; s++) begin
            while (int'($urandom_range(99)) < gap_pct) begin
                bus.in_valid = 1'b0;
                bus.in       = gap_one ? 1'b1 : 1'($urandom_range(1));
                tick();
                chk("gap_in_ready", int'(bus.in_ready), 1);
            end
            b = (int'($urandom_range(99)) < p_pct);
            bus.in_valid = 1'b1;
            bus.in       = b;
            ones += int'(b);
            if (s == W - 1) begin
                sb_q.push_back(ones);
                last_exp = ones;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("out_valid_latency", int'(bus.out_valid), 1);
        chk("done_in_ready", int'(bus.in_ready), 0);
        chk("out_value", int'(bus.out), ones);
    endtask

    // Stall the consumer for 'hold' cycles (feeding valid 1s and random start), then accept.
    task automatic finish(input int hold, input bit chain);
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.in       = 1'b1;
            bus.start    = 1'($urandom_range(1));
            tick();
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_out", int'(bus.out), last_exp);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.start     = chain;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("ack_busy", int'(bus.busy), int'(chain));
        chk("ack_out_valid", int'(bus.out_valid), 0);
        chk("ack_in_ready", int'(bus.in_ready), int'(chain));
        chk("ack_out_hold", int'(bus.out), last_exp);
        chained = chain;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_out", int'(bus.out), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst_ni = 1'b1;
        tick();
        // Start ignored if in_valid alone; IDLE stays idle
        bus.in_valid = 1'b1;
        bus.in       = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("idle_busy", int'(bus.busy), 0);

        // All ones, all zeros, gaps carrying 1s
        start_idle(); window(100, 0, 1'b0); finish(0, 1'b0);
        start_idle(); window(0, 0, 1'b0);   finish(2, 1'b0);
        start_idle(); window(33, 50, 1'b1); finish(1, 1'b0);

        // Long stall with dropped valid 1s, then back-to-back window
        start_idle(); window(50, 20, 1'b0); finish(10, 1'b1);
        window(100, 0, 1'b0); finish(0, 1'b0);

        // Asynchronous reset after 7 samples discards the partial window
        start_idle();
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = 1'($urandom_range(1));
            tick();
        end
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_out", int'(bus.out), 0);
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_in_ready", int'(bus.in_ready), 0);
        chk("arst_busy", int'(bus.busy), 0);
        bus.in_valid = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        last_exp = 0;
        start_idle(); window(60, 30, 1'b0); finish(0, 1'b0);

        // Randomized windows, stalls and chaining
        for (int n = 0; n < 20; n++) begin
            if (!chained) start_idle();
            window(int'($urandom_range(100)), int'($urandom_range(50)), 1'($urandom_range(1)));
            finish(int'($urandom_range(3)), 1'($urandom_range(1)));
        end
        if (chained) begin
            window(70, 10, 1'b0);
            finish(0, 1'b0);
        end

        tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
